// File: rtl/input_port_unit_pkg.sv
// Shared definitions for the router input port unit.
//   - dst_e       : 3-bit route codes presented to the switch allocator
//   - ipu_state_e : input port FSM state encodings
//   - dst_x_lsb / dst_y_lsb : destination field offsets inside a flit (fields sit in the MSBs)
//   - xy_route    : dimension-ordered (X first, then Y) route computation
package input_port_unit_pkg;

    // One-hot output port codes; all-zero means "no request".
    typedef enum logic [2:0] {
        DstEmpty    = 3'b000,
        DstOutX1    = 3'b001,
        DstOutY1    = 3'b010,
        DstOutLocal = 3'b100
    } dst_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRoute = 2'd1,
        StWait  = 2'd2
    } ipu_state_e;

    localparam int unsigned StatW = 16;

    // x field occupies flit[data_w-1 -: x_w]
    function automatic int unsigned dst_x_lsb(input int unsigned data_w, input int unsigned x_w);
        return data_w - x_w;
    endfunction

    // y field sits directly below the x field
    function automatic int unsigned dst_y_lsb(input int unsigned data_w, input int unsigned x_w,
                                              input int unsigned y_w);
        return data_w - x_w - y_w;
    endfunction

    function automatic dst_e xy_route(input int unsigned dst_x, input int unsigned dst_y,
                                      input int unsigned my_x, input int unsigned my_y);
        if (dst_x != my_x) begin
            return DstOutX1;
        end
        if (dst_y != my_y) begin
            return DstOutY1;
        end
        return DstOutLocal;
    endfunction

endpackage

// File: rtl/input_port_unit_if.sv
// Handshake bundle between upstream link, input port unit and switch allocator/crossbar.
// Parameters: DATA_W (flit width), CNT_W (occupancy width = $clog2(DEPTH)+1).
// Signals:
//   in_valid, in_flit, in_ready : upstream flit handshake
//   dst, dst_en                 : route code and its one-cycle load strobe
//   grant                       : allocator pops the head flit
//   out_flit, out_valid         : head flit on the crossbar input
//   count                       : FIFO occupancy
//   fwd_cnt, stall_cnt          : statistics, present only when IPU_STATS_EN is defined
// Modports: slave (the input port unit), master (the environment driving it).
interface input_port_unit_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 3
);
    import input_port_unit_pkg::*;

    logic              in_valid;
    logic [DATA_W-1:0] in_flit;
    logic              in_ready;
    dst_e              dst;
    logic              dst_en;
    logic              grant;
    logic [DATA_W-1:0] out_flit;
    logic              out_valid;
    logic [CNT_W-1:0]  count;
`ifdef IPU_STATS_EN
    logic [StatW-1:0]  fwd_cnt;
    logic [StatW-1:0]  stall_cnt;

    modport slave (
        input  in_valid, in_flit, grant,
        output in_ready, dst, dst_en, out_flit, out_valid, count, fwd_cnt, stall_cnt
    );

    modport master (
        output in_valid, in_flit, grant,
        input  in_ready, dst, dst_en, out_flit, out_valid, count, fwd_cnt, stall_cnt
    );
`else
    modport slave (
        input  in_valid, in_flit, grant,
        output in_ready, dst, dst_en, out_flit, out_valid, count
    );

    modport master (
        output in_valid, in_flit, grant,
        input  in_ready, dst, dst_en, out_flit, out_valid, count
    );
`endif

endinterface

// File: rtl/input_port_unit_sync_fifo.sv
// Circular FIFO with wrapping read/write pointers and an explicit occupancy count.
// Parameters: DATA_W (entry width), DEPTH (entries, power of two, >= 2).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push, wdata : write request; ignored when full (no bypass even with a same-cycle pop)
//   pop         : read request; ignored when empty
//   rdata       : head entry, combinational
//   full, empty : occupancy flags
//   count       : occupancy, $clog2(DEPTH)+1 bits
module sync_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       pop,
    output logic [DATA_W-1:0]          rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW-1:0]   rd_ptr_q;
    logic [CntW-1:0]   count_q;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; the count makes stale entries invisible.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/input_port_unit.sv
// Router input port: buffers single-flit packets, computes the XY route of the head flit,
// strobes the route code to the switch allocator and holds the head flit until granted.
// Parameters: DATA_W, DEPTH, X_W, Y_W (destination field widths in the flit MSBs), MY_X, MY_Y.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : input_port_unit_if.slave (upstream handshake, dst/dst_en, grant,
//                out_flit/out_valid, count)
// Optional feature: define IPU_STATS_EN to add saturating fwd_cnt/stall_cnt counters on bus.
module input_port_unit
    import input_port_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned X_W    = 2,
    parameter int unsigned Y_W    = 1,
    parameter int unsigned MY_X   = 0,
    parameter int unsigned MY_Y   = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input_port_unit_if.slave    bus
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam int unsigned XLsb = dst_x_lsb(DATA_W, X_W);
    localparam int unsigned YLsb = dst_y_lsb(DATA_W, X_W, Y_W);

    logic              full;
    logic              empty;
    logic [CntW-1:0]   count;
    logic [DATA_W-1:0] head;
    logic              wr_fire;
    logic              pop;
    logic              more_left;
    logic [X_W-1:0]    head_x;
    logic [Y_W-1:0]    head_y;
    dst_e              route_dst;

    ipu_state_e        state_q;
    dst_e              dst_q;
    logic              dst_en_q;
    logic              out_valid_q;

    assign wr_fire = bus.in_valid && !full;
    // Grants outside WAIT are ignored.
    assign pop     = bus.grant && (state_q == StWait);
    // Occupancy after this cycle's pop, counting a same-cycle write.
    assign more_left = (count > CntW'(1)) || wr_fire;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.in_valid),
        .wdata (bus.in_flit),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign head_x    = head[XLsb +: X_W];
    assign head_y    = head[YLsb +: Y_W];
    assign route_dst = xy_route(32'(head_x), 32'(head_y), MY_X, MY_Y);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            dst_q       <= DstEmpty;
            dst_en_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            dst_en_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!empty) begin
                        state_q <= StRoute;
                    end
                end
                StRoute: begin
                    dst_q       <= route_dst;
                    dst_en_q    <= 1'b1;
                    out_valid_q <= 1'b1;
                    state_q     <= StWait;
                end
                StWait: begin
                    if (pop) begin
                        out_valid_q <= 1'b0;
                        if (more_left) begin
                            state_q <= StRoute;
                        end else begin
                            // Withdraw the allocator request.
                            state_q  <= StIdle;
                            dst_q    <= DstEmpty;
                            dst_en_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.in_ready  = !full;
    assign bus.dst       = dst_q;
    assign bus.dst_en    = dst_en_q;
    assign bus.out_flit  = head;
    assign bus.out_valid = out_valid_q;
    assign bus.count     = count;

`ifdef IPU_STATS_EN
    logic [StatW-1:0] fwd_cnt_q;
    logic [StatW-1:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (pop && (fwd_cnt_q != '1)) begin
                fwd_cnt_q <= fwd_cnt_q + StatW'(1);
            end
            if ((state_q == StWait) && !bus.grant && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + StatW'(1);
            end
        end
    end

    assign bus.fwd_cnt   = fwd_cnt_q;
    assign bus.stall_cnt = stall_cnt_q;
`endif

`ifndef SYNTHESIS
    grant_only_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
        bus.grant |-> (state_q == StWait))
        else $error("grant received outside WAIT");
`endif

endmodule
